fifo_byte_seq: RTL and testbench

Sequencer for the 8-longword DMA FIFO. It moves single bytes between the SCSI side and 32-bit FIFO words, and longwords between the bus side and the FIFO. It owns the byte pointer, the word write/read pointers, the longword count and the full/empty flags. It generates lane enables and word strobes for the FIFO storage array, and sits between the SCSI byte handshake logic and the bus-side DMA state machine.

---
 rtl/fifo_byte_seq.sv | 218 +++++++++++++++++++++
 tb/tb_fifo_byte_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_seq.sv
// fifo_byte_seq: sequencer for the DMA longword FIFO.
// Moves single bytes between the SCSI side and 32-bit FIFO words, and
// whole longwords between the bus side and the FIFO. Owns the byte lane
// pointer, the word write/read pointers, the longword count and the
// FULL/EMPTY flags. It drives lane enables and word strobes into the
// storage array, which lives outside this block.
module fifo_byte_seq #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIR,
  input  logic             START,
  input  logic             ACR_WR,
  input  logic             ODD_START,
  input  logic             FLUSH,
  input  logic             BYTE_REQ,
  output logic             BYTE_ACK,
  input  logic             LW_REQ,
  output logic             LW_ACK,
  output logic [1:0]       BPTR,
  output logic [PTR_W-1:0] WPTR,
  output logic [PTR_W-1:0] RPTR,
  output logic [3:0]       BYTE_LANE,
  output logic             WORD_WE,
  output logic [PTR_W:0]   COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_FLUSHING = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_e;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [1:0]       bptr_q, bptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             byte_ack_q, byte_ack_d;
  logic             lw_ack_q, lw_ack_d;

  // Accept and bookkeeping strobes for the current cycle.
  logic byte_ok;        // byte transfer accepted this cycle
  logic lw_ok;          // longword transfer accepted this cycle
  logic byte_word_done; // accepted byte was lane 3, word boundary crossed
  logic partial_commit; // FLUSHING pushes a partially filled word
  logic word_in;        // one complete word enters the FIFO
  logic word_out;       // one complete word leaves the FIFO

  // Decide which requests are accepted. The ACK cycle blocks a second
  // accept of the same REQ, and FULL/EMPTY are the pre-cycle values so a
  // simultaneous fill and drain cannot overrun either boundary.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    byte_ok        = 1'b0;
    lw_ok          = 1'b0;
    byte_word_done = 1'b0;
    partial_commit = 1'b0;

    if (state_q == S_RUN && BYTE_REQ && !byte_ack_q) begin
      byte_ok = dir_q ? !full_q : !empty_q;
    end

    // Bus-side drain keeps running while a partial word is being committed.
    if ((state_q == S_RUN || (state_q == S_FLUSHING && dir_q)) &&
        LW_REQ && !lw_ack_q) begin
      lw_ok = dir_q ? !empty_q : !full_q;
    end

    byte_word_done = byte_ok && (bptr_q == 2'd3);

    if (state_q == S_FLUSHING && !full_q && bptr_q != 2'd0) begin
      partial_commit = 1'b1;
    end
  end

  // Direction decides which side adds words and which side removes them.
  always_comb begin
    word_in  = 1'b0;
    word_out = 1'b0;
    if (dir_q) begin
      word_in  = byte_word_done || partial_commit;
      word_out = lw_ok;
    end else begin
      word_in  = lw_ok;
      word_out = byte_word_done;
    end
  end

  // Next-state for the control FSM and the latched transfer direction.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          dir_d   = DIR;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (FLUSH) begin
          state_d = (dir_q && bptr_q != 2'd0) ? S_FLUSHING : S_WAIT_ACK;
        end
      end
      S_FLUSHING: begin
        // Hold here until there is room for the partial word.
        if (!full_q) begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next-state for pointers, count and flags.
  always_comb begin
    bptr_d = bptr_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;

    if (state_q == S_IDLE && ACR_WR) begin
      // An odd word address means the transfer begins in the upper halfword.
      bptr_d = ODD_START ? 2'b10 : 2'b00;
    end else if (byte_ok) begin
      // Lane 3 wraps naturally back to lane 0.
      bptr_d = bptr_q + 2'd1;
    end else if (partial_commit) begin
      bptr_d = 2'd0;
    end

    if (word_in) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (word_out) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    unique case ({word_in, word_out})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == '0);

    byte_ack_d = byte_ok;
    lw_ack_d   = lw_ok;
  end

  // State register; asynchronous reset drops any pending ACK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      bptr_q     <= 2'd0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      byte_ack_q <= 1'b0;
      lw_ack_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      dir_q      <= dir_d;
      bptr_q     <= bptr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      byte_ack_q <= byte_ack_d;
      lw_ack_q   <= lw_ack_d;
    end
  end

  // Storage strobes are combinational in the accept cycle.
  always_comb begin
    BYTE_LANE = 4'b0000;
    WORD_WE   = 1'b0;
    if (byte_ok && dir_q) begin
      BYTE_LANE = 4'b0001 << bptr_q;
    end
    if (lw_ok && !dir_q) begin
      WORD_WE = 1'b1;
    end
  end

  assign BYTE_ACK = byte_ack_q;
  assign LW_ACK   = lw_ack_q;
  assign BPTR     = bptr_q;
  assign WPTR     = wptr_q;
  assign RPTR     = rptr_q;
  assign COUNT    = count_q;
  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_byte_seq.sv
// Directed testbench for fifo_byte_seq with hand-computed expectations.
module tb_fifo_byte_seq;

  logic       CLK;
  logic       RST;
  logic       DIR;
  logic       START;
  logic       ACR_WR;
  logic       ODD_START;
  logic       FLUSH;
  logic       BYTE_REQ;
  logic       BYTE_ACK;
  logic       LW_REQ;
  logic       LW_ACK;
  logic [1:0] BPTR;
  logic [2:0] WPTR;
  logic [2:0] RPTR;
  logic [3:0] BYTE_LANE;
  logic       WORD_WE;
  logic [3:0] COUNT;
  logic       FULL;
  logic       EMPTY;
  logic       BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_byte_seq #(.DEPTH(8), .PTR_W(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIR       (DIR),
    .START     (START),
    .ACR_WR    (ACR_WR),
    .ODD_START (ODD_START),
    .FLUSH     (FLUSH),
    .BYTE_REQ  (BYTE_REQ),
    .BYTE_ACK  (BYTE_ACK),
    .LW_REQ    (LW_REQ),
    .LW_ACK    (LW_ACK),
    .BPTR      (BPTR),
    .WPTR      (WPTR),
    .RPTR      (RPTR),
    .BYTE_LANE (BYTE_LANE),
    .WORD_WE   (WORD_WE),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
  endtask

  task automatic start_xfer(input logic d);
    DIR   = d;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // One byte handshake: REQ, accept edge, ACK cycle.
  task automatic send_byte(input string tag, input logic [3:0] exp_lane);
    BYTE_REQ = 1'b1;
    #1;
    check({tag, "_lane"}, BYTE_LANE, exp_lane);
    tick();
    check({tag, "_ack"}, BYTE_ACK, 1'b1);
    BYTE_REQ = 1'b0;
    tick();
  endtask

  // Byte handshake without per-byte checks, for bulk filling.
  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      BYTE_REQ = 1'b1;
      tick();
      BYTE_REQ = 1'b0;
      tick();
    end
  endtask

  task automatic send_lw(input string tag, input logic exp_we);
    LW_REQ = 1'b1;
    #1;
    check({tag, "_we"}, WORD_WE, exp_we);
    tick();
    check({tag, "_ack"}, LW_ACK, 1'b1);
    LW_REQ = 1'b0;
    tick();
  endtask

  initial begin
    // NOTE: testbench drives inputs with blocking assignments away from the clock edge.
    RST = 1'b1; DIR = 1'b0; START = 1'b0; ACR_WR = 1'b0; ODD_START = 1'b0;
    FLUSH = 1'b0; BYTE_REQ = 1'b0; LW_REQ = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst_bptr", BPTR, 2'd0);
    check("rst_wptr", WPTR, 3'd0);
    check("rst_rptr", RPTR, 3'd0);
    check("rst_count", COUNT, 4'd0);
    check("rst_empty", EMPTY, 1'b1);
    check("rst_full", FULL, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_back", BYTE_ACK, 1'b0);
    check("rst_lack", LW_ACK, 1'b0);
    check("rst_lane", BYTE_LANE, 4'b0000);
    check("rst_we", WORD_WE, 1'b0);
    RST = 1'b0;
    tick();

    // Odd start: BPTR loads 2, two bytes complete one word.
    ACR_WR = 1'b1; ODD_START = 1'b1;
    tick();
    ACR_WR = 1'b0; ODD_START = 1'b0;
    check("odd_bptr_load", BPTR, 2'd2);
    start_xfer(1'b1);
    check("odd_busy", BUSY, 1'b1);
    send_byte("odd_b0", 4'b0100);
    check("odd_bptr3", BPTR, 2'd3);
    check("odd_count0", COUNT, 4'd0);
    send_byte("odd_b1", 4'b1000);
    check("odd_bptr0", BPTR, 2'd0);
    check("odd_wptr", WPTR, 3'd1);
    check("odd_count1", COUNT, 4'd1);
    check("odd_empty", EMPTY, 1'b0);
    // Aligned FLUSH goes straight to WAIT_ACK: IDLE two edges later.
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("odd_flush_busy1", BUSY, 1'b1);
    tick();
    check("odd_flush_idle", BUSY, 1'b0);
    check("odd_retained_count", COUNT, 4'd1);

    // Fill to FULL with 32 bytes, then a 33rd byte waits on a drain.
    do_reset();
    start_xfer(1'b1);
    push_bytes(31);
    check("full_count31", COUNT, 4'd7);
    send_byte("full_b32", 4'b1000);
    check("full_count", COUNT, 4'd8);
    check("full_flag", FULL, 1'b1);
    check("full_wptr_wrap", WPTR, 3'd0);
    BYTE_REQ = 1'b1;
    #1;
    check("full_no_lane", BYTE_LANE, 4'b0000);
    tick();
    check("full_no_ack1", BYTE_ACK, 1'b0);
    tick();
    check("full_no_ack2", BYTE_ACK, 1'b0);
    check("full_bptr_hold", BPTR, 2'd0);
    LW_REQ = 1'b1;
    tick();
    LW_REQ = 1'b0;
    check("full_lw_ack", LW_ACK, 1'b1);
    check("full_drain_count", COUNT, 4'd7);
    check("full_drain_rptr", RPTR, 3'd1);
    check("full_drain_flag", FULL, 1'b0);
    check("full_b33_not_yet", BYTE_ACK, 1'b0);
    tick();
    check("full_b33_ack", BYTE_ACK, 1'b1);
    check("full_b33_bptr", BPTR, 2'd1);
    BYTE_REQ = 1'b0;
    tick();

    // Five bytes then FLUSH commits the partial word.
    do_reset();
    start_xfer(1'b1);
    push_bytes(4);
    check("flush_count1", COUNT, 4'd1);
    send_byte("flush_b5", 4'b0001);
    check("flush_bptr1", BPTR, 2'd1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush_busy_a", BUSY, 1'b1);
    check("flush_count_pre", COUNT, 4'd1);
    tick();
    check("flush_busy_b", BUSY, 1'b1);
    check("flush_count2", COUNT, 4'd2);
    check("flush_bptr0", BPTR, 2'd0);
    check("flush_wptr2", WPTR, 3'd2);
    tick();
    check("flush_idle", BUSY, 1'b0);

    // Memory to SCSI: two longwords in, eight bytes out.
    do_reset();
    start_xfer(1'b0);
    send_lw("m2s_lw0", 1'b1);
    send_lw("m2s_lw1", 1'b1);
    check("m2s_count2", COUNT, 4'd2);
    check("m2s_wptr2", WPTR, 3'd2);
    send_byte("m2s_b0", 4'b0000);
    check("m2s_bptr1", BPTR, 2'd1);
    push_bytes(3);
    check("m2s_count1", COUNT, 4'd1);
    check("m2s_rptr1", RPTR, 3'd1);
    push_bytes(4);
    check("m2s_count0", COUNT, 4'd0);
    check("m2s_rptr2", RPTR, 3'd2);
    check("m2s_empty", EMPTY, 1'b1);
    BYTE_REQ = 1'b1;
    tick();
    check("m2s_b9_no_ack1", BYTE_ACK, 1'b0);
    tick();
    check("m2s_b9_no_ack2", BYTE_ACK, 1'b0);
    BYTE_REQ = 1'b0;
    tick();

    // Lane-3 byte and longword drain in one cycle leave COUNT unchanged.
    do_reset();
    start_xfer(1'b1);
    push_bytes(15);
    check("sim_count3", COUNT, 4'd3);
    check("sim_bptr3", BPTR, 2'd3);
    BYTE_REQ = 1'b1;
    LW_REQ   = 1'b1;
    #1;
    check("sim_lane", BYTE_LANE, 4'b1000);
    tick();
    BYTE_REQ = 1'b0;
    LW_REQ   = 1'b0;
    check("sim_back", BYTE_ACK, 1'b1);
    check("sim_lack", LW_ACK, 1'b1);
    check("sim_count", COUNT, 4'd3);
    check("sim_wptr", WPTR, 3'd4);
    check("sim_rptr", RPTR, 3'd1);
    check("sim_bptr", BPTR, 2'd0);
    tick();

    // Asynchronous reset in RUN with COUNT=4 and a byte being accepted.
    do_reset();
    start_xfer(1'b1);
    push_bytes(16);
    check("ar_count4", COUNT, 4'd4);
    BYTE_REQ = 1'b1;
    #1;
    check("ar_lane_pre", BYTE_LANE, 4'b0001);
    #2;
    RST = 1'b1;
    #1;
    check("ar_count", COUNT, 4'd0);
    check("ar_wptr", WPTR, 3'd0);
    check("ar_bptr", BPTR, 2'd0);
    check("ar_empty", EMPTY, 1'b1);
    check("ar_busy", BUSY, 1'b0);
    check("ar_lane", BYTE_LANE, 4'b0000);
    tick();
    check("ar_no_ack1", BYTE_ACK, 1'b0);
    RST = 1'b0;
    tick();
    check("ar_no_ack2", BYTE_ACK, 1'b0);
    check("ar_idle", BUSY, 1'b0);
    BYTE_REQ = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
